// File: rtl/ama_riscv_ex_opsel.sv
// ama_riscv_ex_opsel: ID/EX operand-select register feeding ama_riscv_alu.
// Define AMA_RISCV_FWD_EN for EX/MEM/WB bypass; otherwise stall until write-back.
package ama_riscv_ex_pkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } alu_op_t;
endpackage

module ama_riscv_ex_opsel
    import ama_riscv_ex_pkg::*;
#(
    parameter int ARCH_WIDTH = 32,
    parameter int RF_AW      = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_op_t               in_alu_op,
    input  logic [1:0]            in_a_sel,
    input  logic                  in_b_sel,
    input  logic [RF_AW-1:0]      in_rs1_addr,
    input  logic [RF_AW-1:0]      in_rs2_addr,
    input  logic [ARCH_WIDTH-1:0] in_rs1_data,
    input  logic [ARCH_WIDTH-1:0] in_rs2_data,
    input  logic [ARCH_WIDTH-1:0] in_pc,
    input  logic [ARCH_WIDTH-1:0] in_imm,
    input  logic [RF_AW-1:0]      in_rd,
    input  logic                  ex_valid,
    input  logic [RF_AW-1:0]      ex_rd,
    input  logic                  ex_we,
    input  logic                  ex_is_load,
    input  logic [ARCH_WIDTH-1:0] ex_res,
    input  logic                  mem_valid,
    input  logic [RF_AW-1:0]      mem_rd,
    input  logic                  mem_we,
    input  logic [ARCH_WIDTH-1:0] mem_res,
    input  logic                  wb_valid,
    input  logic [RF_AW-1:0]      wb_rd,
    input  logic                  wb_we,
    input  logic [ARCH_WIDTH-1:0] wb_res,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output alu_op_t               alu_op_q,
    output logic [ARCH_WIDTH-1:0] alu_a,
    output logic [ARCH_WIDTH-1:0] alu_b,
    output logic [RF_AW-1:0]      rd_q,
    output logic [CNT_W-1:0]      stall_cnt
);
    localparam logic [1:0] ASEL_RS1 = 2'd0;
    localparam logic [1:0] ASEL_PC  = 2'd1;

    logic                  out_valid_q, out_valid_d;
    alu_op_t               alu_op_r, alu_op_d;
    logic [ARCH_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [ARCH_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [RF_AW-1:0]      rd_r, rd_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic rs1_used, rs2_used, rs1_nz, rs2_nz;
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic hazard, accept;
    logic [ARCH_WIDTH-1:0] rs1_val, rs2_val, op_a, op_b;

    assign rs1_used = (in_a_sel == ASEL_RS1);
    assign rs2_used = !in_b_sel;
    assign rs1_nz   = (in_rs1_addr != '0);
    assign rs2_nz   = (in_rs2_addr != '0);

    // x0 never matches a producer
    assign ex_hit1  = ex_valid && ex_we && rs1_nz && (ex_rd == in_rs1_addr);
    assign ex_hit2  = ex_valid && ex_we && rs2_nz && (ex_rd == in_rs2_addr);
    assign mem_hit1 = mem_valid && mem_we && rs1_nz && (mem_rd == in_rs1_addr);
    assign mem_hit2 = mem_valid && mem_we && rs2_nz && (mem_rd == in_rs2_addr);
    assign wb_hit1  = wb_valid && wb_we && rs1_nz && (wb_rd == in_rs1_addr);
    assign wb_hit2  = wb_valid && wb_we && rs2_nz && (wb_rd == in_rs2_addr);

`ifdef AMA_RISCV_FWD_EN
    logic ld_hit1, ld_hit2;

    assign ld_hit1 = ex_valid && ex_is_load && rs1_nz && (ex_rd == in_rs1_addr);
    assign ld_hit2 = ex_valid && ex_is_load && rs2_nz && (ex_rd == in_rs2_addr);
    assign hazard  = in_valid && ((rs1_used && ld_hit1) || (rs2_used && ld_hit2));

    // Youngest producer wins
    always_comb begin
        rs1_val = in_rs1_data;
        if (ex_hit1)       rs1_val = ex_res;
        else if (mem_hit1) rs1_val = mem_res;
        else if (wb_hit1)  rs1_val = wb_res;
        if (!rs1_nz)       rs1_val = '0;
    end

    always_comb begin
        rs2_val = in_rs2_data;
        if (ex_hit2)       rs2_val = ex_res;
        else if (mem_hit2) rs2_val = mem_res;
        else if (wb_hit2)  rs2_val = wb_res;
        if (!rs2_nz)       rs2_val = '0;
    end
`else
    logic unused_byp;

    assign unused_byp = ^{ex_is_load, ex_res, mem_res, wb_res};
    assign hazard = in_valid &&
                    ((rs1_used && (ex_hit1 || mem_hit1 || wb_hit1)) ||
                     (rs2_used && (ex_hit2 || mem_hit2 || wb_hit2)));
    assign rs1_val = rs1_nz ? in_rs1_data : '0;
    assign rs2_val = rs2_nz ? in_rs2_data : '0;
`endif

    always_comb begin
        op_a = '0;
        unique case (1'b1)
            (in_a_sel == ASEL_RS1): op_a = rs1_val;
            (in_a_sel == ASEL_PC):  op_a = in_pc;
            default:                op_a = '0;
        endcase
    end

    assign op_b = in_b_sel ? in_imm : rs2_val;

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_op_d    = alu_op_r;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rd_d        = rd_r;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_op_d    = in_alu_op;
            alu_a_d     = op_a;
            alu_b_d     = op_b;
            rd_d        = in_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (hazard && !flush && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_op_r    <= ALU_OP_ADD;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rd_r        <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_op_r    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rd_r        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op_q  = alu_op_r;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rd_q      = rd_r;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ama_riscv_ex_opsel.sv
// tb_ama_riscv_ex_opsel: scoreboard bench for the ID/EX operand-select register.
// Reference model follows the bypass/hazard rules; honours AMA_RISCV_FWD_EN.
module tb_ama_riscv_ex_opsel;
    import ama_riscv_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    alu_op_t     in_alu_op;
    logic [1:0]  in_a_sel;
    logic        in_b_sel;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
    logic        ex_valid, ex_we, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        mem_valid, mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_res;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    alu_op_t     alu_op_q;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  rd_q;
    logic [31:0] stall_cnt;

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    ama_riscv_ex_opsel dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_res(ex_res),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_we(mem_we), .mem_res(mem_res),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_res(wb_res),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op_q(alu_op_q), .alu_a(alu_a), .alu_b(alu_b),
        .rd_q(rd_q), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Value a source register should read as at this moment
    function automatic logic [31:0] model_src(logic [4:0] ad, logic [31:0] rf);
        if (ad == 5'd0) return 32'd0;
`ifdef AMA_RISCV_FWD_EN
        if (ex_valid && ex_we && ex_rd == ad) return ex_res;
        if (mem_valid && mem_we && mem_rd == ad) return mem_res;
        if (wb_valid && wb_we && wb_rd == ad) return wb_res;
`endif
        return rf;
    endfunction

    function automatic bit model_hazard();
        bit          h = 0;
        bit          used[2];
        logic [4:0]  src[2];
        used[0] = (in_a_sel == 2'd0);
        used[1] = (in_b_sel == 1'b0);
        src[0]  = in_rs1_addr;
        src[1]  = in_rs2_addr;
        for (int s = 0; s < 2; s++) begin
            if (used[s] && src[s] != 5'd0) begin
`ifdef AMA_RISCV_FWD_EN
                if (ex_valid && ex_is_load && ex_rd == src[s]) h = 1;
`else
                if (ex_valid && ex_we && ex_rd == src[s]) h = 1;
                if (mem_valid && mem_we && mem_rd == src[s]) h = 1;
                if (wb_valid && wb_we && wb_rd == src[s]) h = 1;
`endif
            end
        end
        return in_valid && h;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.op = in_alu_op;
        e.a  = (in_a_sel == 2'd0) ? model_src(in_rs1_addr, in_rs1_data) :
               (in_a_sel == 2'd1) ? in_pc : 32'd0;
        e.b  = in_b_sel ? in_imm : model_src(in_rs2_addr, in_rs2_data);
        e.rd = in_rd;
        return e;
    endfunction

    task automatic idle();
        rst = 0; in_valid = 0; in_alu_op = ALU_OP_ADD; in_a_sel = 0; in_b_sel = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_pc = 0; in_imm = 0;
        ex_valid = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0; ex_res = 0;
        mem_valid = 0; mem_rd = 0; mem_we = 0; mem_res = 0;
        wb_valid = 0; wb_rd = 0; wb_we = 0; wb_res = 0;
        flush = 0; out_ready = 0;
    endtask

    task automatic randomize_inputs();
        in_valid    = ($urandom_range(0, 9) < 8);
        in_alu_op   = alu_op_t'($urandom_range(0, 9));
        in_a_sel    = 2'($urandom_range(0, 3));
        in_b_sel    = 1'($urandom_range(0, 1));
        in_rs1_addr = 5'($urandom_range(0, 4));
        in_rs2_addr = 5'($urandom_range(0, 4));
        in_rd       = 5'($urandom);
        in_rs1_data = $urandom; in_rs2_data = $urandom;
        in_pc       = $urandom; in_imm = $urandom;
        ex_valid    = 1'($urandom_range(0, 1));
        ex_rd       = 5'($urandom_range(0, 4));
        ex_we       = ($urandom_range(0, 9) < 7);
        ex_is_load  = ($urandom_range(0, 9) < 3);
        ex_res      = $urandom;
        mem_valid   = 1'($urandom_range(0, 1));
        mem_rd      = 5'($urandom_range(0, 4));
        mem_we      = ($urandom_range(0, 9) < 7);
        mem_res     = $urandom;
        wb_valid    = 1'($urandom_range(0, 1));
        wb_rd       = 5'($urandom_range(0, 4));
        wb_we       = ($urandom_range(0, 9) < 7);
        wb_res      = $urandom;
        flush       = ($urandom_range(0, 19) == 0);
        out_ready   = ($urandom_range(0, 9) < 7);
    endtask

    // Called at posedge+1 with inputs applied; returns at next posedge+1
    task automatic step();
        bit ov, hz, rdy;
        if (rst) begin
            #2;
            sb.delete();
            exp_cnt = 0;
        end else begin
            ov  = (sb.size() != 0);
            hz  = model_hazard();
            rdy = (!ov || out_ready) && !hz && !flush;
            #2;
            chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
            chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, exp_cnt});
            if (in_valid && rdy) sb.push_back(model_out());
            if (hz && !flush && exp_cnt != 32'hffff_ffff) exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_alu_op", {60'd0, alu_op_q}, {60'd0, ALU_OP_ADD});
        chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
        chk("rst_rd", {59'd0, rd_q}, 64'd0);
        chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    endtask

    // Monitor: compares the held entry every cycle, retires it on out_ready
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
                if (out_valid && sb.size() != 0) begin
                    chk("alu_op", {60'd0, alu_op_q}, {60'd0, sb[0].op});
                    chk("alu_a", {32'd0, alu_a}, {32'd0, sb[0].a});
                    chk("alu_b", {32'd0, alu_b}, {32'd0, sb[0].b});
                    chk("rd", {59'd0, rd_q}, {59'd0, sb[0].rd});
                    if (out_ready) void'(sb.pop_front());
                end
                if (flush) sb.delete();
            end
        end
    end

    initial begin
        idle();
        rst = 1;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 0;
        chk_reset();

        // basic RS1 + IMM
        in_valid = 1; in_alu_op = ALU_OP_ADD; in_a_sel = 0; in_rs1_addr = 3;
        in_rs1_data = 5; in_b_sel = 1; in_imm = 7; in_rd = 1;
        step();
        idle();
        out_ready = 1;
        step();

`ifdef AMA_RISCV_FWD_EN
        in_valid = 1; in_a_sel = 0; in_rs1_addr = 4; in_rs1_data = 32'h99;
        in_b_sel = 1; in_imm = 1; out_ready = 1;
        ex_valid = 1; ex_rd = 4; ex_we = 1; ex_res = 32'h11;
        mem_valid = 1; mem_rd = 4; mem_we = 1; mem_res = 32'h22;
        step();
        ex_valid = 0;
        step();
        in_rs1_addr = 0;
        step();
        idle();
        out_ready = 1;
        step();
`endif

        // load-use on rs2
        in_valid = 1; in_a_sel = 2; in_b_sel = 0; in_rs2_addr = 9;
        in_rs2_data = 32'h1234; out_ready = 1;
        ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 9;
        step();
        ex_valid = 0;
        step();
        idle();
        out_ready = 1;
        step();

        // backpressure: hold 3 cycles with a new instruction waiting
        in_valid = 1; in_a_sel = 1; in_pc = 32'h100; in_b_sel = 1; in_imm = 32'hff;
        in_rd = 5;
        step();
        in_pc = 32'h200; in_rd = 6;
        out_ready = 0;
        step();
        step();
        step();
        out_ready = 1;
        step();
        idle();
        out_ready = 1;
        step();

        // flush with a held entry and a new instruction
        in_valid = 1; in_a_sel = 1; in_pc = 32'h300; in_b_sel = 1;
        step();
        in_pc = 32'h400; flush = 1; out_ready = 0;
        step();
        idle();
        out_ready = 1;
        step();

        // stall until write-back without bypass; PC operand never stalls
        in_valid = 1; in_a_sel = 0; in_rs1_addr = 2; in_b_sel = 1; out_ready = 1;
        wb_valid = 1; wb_rd = 2; wb_we = 1; wb_res = 32'h55;
        step();
        step();
        in_a_sel = 1; in_pc = 32'h800;
        step();
        idle();
        out_ready = 1;
        step();

        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            step();
        end

        // reset mid-operation
        randomize_inputs();
        rst = 1; in_valid = 1;
        step();
        rst = 0;
        chk_reset();

        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            step();
        end
        idle();
        out_ready = 1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
